// File: rtl/hir_launch_pkg.sv
// hir_launch_pkg: launcher FSM state type and default port widths shared by the launcher slice
package hir_launch_pkg;
  localparam int DEF_ADDR_W = 7;
  localparam int DEF_RD_DATA_W = 32;
  localparam int DEF_WR_DATA_W = 64;
  typedef enum logic [1:0] {IDLE, START, RUN, DONE} state_t;
endpackage

// File: rtl/hir_kernel_launcher_if.sv
// hir_kernel_launcher_if: launch command channel; cmd_valid/cmd_ready handshake carrying the three per-launch base addresses
interface hir_kernel_launcher_if #(parameter int ADDR_W = hir_launch_pkg::DEF_ADDR_W);
  logic cmd_valid;
  logic cmd_ready;
  logic [ADDR_W-1:0] cmd_rd_base0;
  logic [ADDR_W-1:0] cmd_rd_base1;
  logic [ADDR_W-1:0] cmd_wr_base;
  modport master (output cmd_valid, cmd_rd_base0, cmd_rd_base1, cmd_wr_base, input cmd_ready);
  modport slave (input cmd_valid, cmd_rd_base0, cmd_rd_base1, cmd_wr_base, output cmd_ready);
endinterface

// File: rtl/hir_addr_relocate.sv
// hir_addr_relocate: one memory port; k_addr+base -> m_addr (mod 2^ADDR_W), k_en gated by gate -> m_en, stray flags k_en while not busy
module hir_addr_relocate #(
  parameter int ADDR_W = hir_launch_pkg::DEF_ADDR_W
) (
  input  logic [ADDR_W-1:0] k_addr,
  input  logic [ADDR_W-1:0] base,
  input  logic              k_en,
  input  logic              busy,
  input  logic              gate,
  output logic [ADDR_W-1:0] m_addr,
  output logic              m_en,
  output logic              stray
);
  assign m_addr = k_addr + base;
  assign m_en = k_en & gate;
  assign stray = k_en & ~busy;
endmodule

// File: rtl/hir_kernel_launcher.sv
// hir_kernel_launcher: launches one static-schedule HIR kernel per command and relocates its memory traffic
// ports: clk/rst; cmd (launch channel, slave); k_* kernel side (start, 2 read ports, 1 write port);
// m_* memory side (relocated, gated); busy/done/err_stray/launch_count status
module hir_kernel_launcher
  import hir_launch_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int RD_DATA_W = DEF_RD_DATA_W,
  parameter int WR_DATA_W = DEF_WR_DATA_W,
  parameter int KERNEL_LATENCY = 8,
  parameter int CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  hir_kernel_launcher_if.slave cmd,
  output logic                 k_start,
  input  logic [ADDR_W-1:0]    k_addr0,
  input  logic [ADDR_W-1:0]    k_addr1,
  input  logic                 k_rd_en0,
  input  logic                 k_rd_en1,
  output logic [RD_DATA_W-1:0] k_rd_data0,
  output logic [RD_DATA_W-1:0] k_rd_data1,
  input  logic [ADDR_W-1:0]    k_addr2,
  input  logic                 k_wr_en2,
  input  logic [WR_DATA_W-1:0] k_wr_data2,
  output logic [ADDR_W-1:0]    m_addr0,
  output logic [ADDR_W-1:0]    m_addr1,
  output logic [ADDR_W-1:0]    m_addr2,
  output logic                 m_rd_en0,
  output logic                 m_rd_en1,
  output logic                 m_wr_en2,
  input  logic [RD_DATA_W-1:0] m_rd_data0,
  input  logic [RD_DATA_W-1:0] m_rd_data1,
  output logic [WR_DATA_W-1:0] m_wr_data2,
  output logic                 busy,
  output logic                 done,
  output logic                 err_stray,
  output logic [CNT_W-1:0]     launch_count
);
  localparam int LAT_W = $clog2(KERNEL_LATENCY + 1);
  state_t state;
  logic [LAT_W-1:0] cnt;
  logic [ADDR_W-1:0] base0, base1, base2;
  logic [2:0] stray;
  // busy is registered, so rst is folded in to force enables low in the reset cycle itself
  logic gate;
  assign gate = busy & ~rst;
  assign k_rd_data0 = m_rd_data0;
  assign k_rd_data1 = m_rd_data1;
  assign m_wr_data2 = k_wr_data2;
  hir_addr_relocate #(.ADDR_W(ADDR_W)) u_rel0 (.k_addr(k_addr0), .base(base0), .k_en(k_rd_en0), .busy(busy), .gate(gate), .m_addr(m_addr0), .m_en(m_rd_en0), .stray(stray[0]));
  hir_addr_relocate #(.ADDR_W(ADDR_W)) u_rel1 (.k_addr(k_addr1), .base(base1), .k_en(k_rd_en1), .busy(busy), .gate(gate), .m_addr(m_addr1), .m_en(m_rd_en1), .stray(stray[1]));
  hir_addr_relocate #(.ADDR_W(ADDR_W)) u_rel2 (.k_addr(k_addr2), .base(base2), .k_en(k_wr_en2), .busy(busy), .gate(gate), .m_addr(m_addr2), .m_en(m_wr_en2), .stray(stray[2]));
  // START plus RUN spans exactly KERNEL_LATENCY cycles: RUN leaves when cnt is about to reach 0
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      base0 <= '0;
      base1 <= '0;
      base2 <= '0;
      k_start <= 1'b0;
      done <= 1'b0;
      busy <= 1'b0;
      cmd.cmd_ready <= 1'b1;
      err_stray <= 1'b0;
      launch_count <= '0;
    end else begin
      err_stray <= err_stray | (|stray);
      k_start <= 1'b0;
      done <= 1'b0;
      case (state)
        IDLE: if (cmd.cmd_valid) begin
          base0 <= cmd.cmd_rd_base0;
          base1 <= cmd.cmd_rd_base1;
          base2 <= cmd.cmd_wr_base;
          state <= START;
          k_start <= 1'b1;
          busy <= 1'b1;
          cmd.cmd_ready <= 1'b0;
        end
        START: begin
          cnt <= LAT_W'(KERNEL_LATENCY - 1);
          state <= (KERNEL_LATENCY == 1) ? DONE : RUN;
          done <= (KERNEL_LATENCY == 1);
          busy <= (KERNEL_LATENCY != 1);
        end
        RUN: begin
          cnt <= cnt - 1'b1;
          if (cnt == LAT_W'(1)) begin
            state <= DONE;
            done <= 1'b1;
            busy <= 1'b0;
          end
        end
        DONE: begin
          launch_count <= launch_count + 1'b1;
          state <= IDLE;
          cmd.cmd_ready <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/hir_kernel_launcher.md
Name: hir_kernel_launcher

Overview:
- Sequencer for one statically scheduled HIR kernel (two 1-cycle-latency read ports, one write port, single-cycle start pulse).
- Accepts launch commands over valid/ready and latches per-launch base addresses.
- Pulses the kernel start input, counts the kernel's fixed schedule length, then signals done.
- Relocates kernel memory traffic by the latched bases, gates enables outside the run window, and sits between the kernel instance and the shared memory banks.

Parameters:
- ADDR_W, 7, address width of all memory ports
- RD_DATA_W, 32, read data width
- WR_DATA_W, 64, write data width
- KERNEL_LATENCY, 8, cycles from start pulse to final kernel memory access inclusive; legal range ≥1
- CNT_W, 16, launch counter width

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- cmd_valid  in  1  launch request
- cmd_ready  out  1  launcher can accept
- cmd_rd_base0  in  ADDR_W  base for read port 0
- cmd_rd_base1  in  ADDR_W  base for read port 1
- cmd_wr_base  in  ADDR_W  base for write port 2
- k_start  out  1  one-cycle start pulse to kernel
- k_addr0/k_addr1  in  ADDR_W  kernel read addresses
- k_rd_en0/k_rd_en1  in  1  kernel read enables
- k_rd_data0/k_rd_data1  out  RD_DATA_W  read data to kernel
- k_addr2  in  ADDR_W  kernel write address
- k_wr_en2  in  1  kernel write enable
- k_wr_data2  in  WR_DATA_W  kernel write data
- m_addr0/m_addr1/m_addr2  out  ADDR_W  relocated memory addresses
- m_rd_en0/m_rd_en1/m_wr_en2  out  1  gated memory enables
- m_rd_data0/m_rd_data1  in  RD_DATA_W  memory read data
- m_wr_data2  out  WR_DATA_W  write data passthrough
- busy  out  1  state is START or RUN
- done  out  1  one-cycle completion pulse
- err_stray  out  1  sticky: kernel enable seen while not busy
- launch_count  out  CNT_W  completed launches

Behaviour:
- FSM states IDLE, START, RUN, DONE.
- IDLE: cmd_ready=1. On cmd_valid, latch the three bases and go to START.
- START: k_start=1 for exactly one cycle; load cnt=KERNEL_LATENCY-1; go to RUN (or DONE if KERNEL_LATENCY=1).
- RUN: decrement cnt; at cnt=0 go to DONE.
- DONE: done=1 for one cycle; launch_count++ (wraps to 0 at 2^CNT_W); go to IDLE.
- Timing: accept in cycle A → k_start in A+1 → done in A+1+KERNEL_LATENCY. cmd_ready=0 from A+1 through the done cycle inclusive; next accept no earlier than A+2+KERNEL_LATENCY.
- Relocation: m_addrN = (k_addrN + baseN) mod 2^ADDR_W, purely combinational. Adds zero latency, so the kernel's 1-cycle read latency is preserved.
- k_rd_dataN = m_rd_dataN and m_wr_data2 = k_wr_data2, combinational.
- Gating: m_*_en = k_*_en & busy.
- Any k enable while not busy is dropped and sets err_stray; err_stray clears only on rst.
- Bases are stable from the START cycle through DONE; cmd_rd_base*/cmd_wr_base changes after accept are ignored.
- Reset: state=IDLE; k_start=0, done=0, busy=0, err_stray=0, launch_count=0, latched bases=0, cnt=0; m_*_en=0 during the rst cycle.
- Reset mid-run aborts without a done pulse and leaves launch_count=0. cmd_ready=1 in the first cycle after rst deasserts.
- cmd_valid asserted in the same cycle as rst is ignored.

Decomposition:
- Package hir_launch_pkg: state enum (IDLE, START, RUN, DONE) and default width constants (ADDR_W=7, RD_DATA_W=32, WR_DATA_W=64).
- Sub-module hir_addr_relocate: adder plus enable gate plus stray detect for one port; instantiated three times.
- FSM, counter and bases live in the top.

Test Plan:
- Reset held 3 cycles, then released → all outputs 0 except cmd_ready=1; launch_count=0.
- Launch with bases 0x10/0x20/0x30 accepted at cycle 0, KERNEL_LATENCY=8; kernel drives k_addr0=0x05, k_rd_en0=1 in cycle 2 → k_start only in cycle 1; m_addr0=0x15, m_rd_en0=1 in cycle 2; done only in cycle 9; launch_count=1 in cycle 10.
- Wrap: rd_base0=0x7E, k_addr0=0x05 → m_addr0=0x03; wr_base=0x7F, k_addr2=0x01 → m_addr2=0x00.
- cmd_valid held high continuously → accepts at cycles 0 and 10; k_start at 1 and 11; cmd_ready low during cycles 1–9.
- k_rd_en1=1 while IDLE → m_rd_en1=0; err_stray=1 from the next cycle and persists through later launches until rst.
- rst asserted in cycle 4 of a run → no done pulse; launch_count stays 0; busy=0 and cmd_ready=1 in the cycle after rst deasserts; a new launch then completes normally.
